onehot_line_sequencer: RTL and testbench

Registered, parametrised one-hot line driver. It generalises the 2-to-4 combinational address decoder to 2..2^ADDR_W lines and produces glitch-free, reset-defined outputs. Besides direct decode it has an autonomous scan mode that walks every line in turn for a programmable dwell time. It sits between a bus-side address source and per-target select/enable lines, such as chip-selects or bank strobes.

---
 rtl/onehot_line_sequencer.sv | 163 ++++++++++++++++
 tb/tb_onehot_line_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/onehot_line_sequencer.sv
// Registered one-hot line driver: direct address decode with hold, plus an
// autonomous scan that walks every line for DWELL cycles each.
//
//   state  | meaning
//   -------+---------------------------------------------
//   S_IDLE | all lines low
//   S_HOLD | one direct-decoded line held, line_valid high
//   S_SCAN | scan in progress, scan_busy high
module onehot_line_sequencer #(
    parameter int ADDR_W    = 3,
    parameter int NUM_LINES = 6,
    parameter int DWELL     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 mode,
    input  logic                 addr_valid,
    input  logic [ADDR_W-1:0]    addr,
    input  logic                 scan_start,
    output logic [NUM_LINES-1:0] line,
    output logic                 line_valid,
    output logic                 addr_err,
    output logic                 scan_busy,
    output logic                 scan_done
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_SCAN = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_LINES-1:0] line_q, line_d;
    logic                 line_valid_q, line_valid_d;
    logic                 addr_err_q, addr_err_d;
    logic                 scan_busy_q, scan_busy_d;
    logic                 scan_done_q, scan_done_d;
    logic [ADDR_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [NUM_LINES-1:0] dec_line;
    logic                 addr_legal;
    logic                 dwell_end;
    logic                 last_line;

    // Address decode: one bit per legal address, zero for illegal ones.
    always_comb begin
        dec_line = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            dec_line[i] = (addr == ADDR_W'(i));
        end
    end

    assign addr_legal = ({1'b0, addr} < (ADDR_W + 1)'(NUM_LINES));
    assign dwell_end  = (cnt_q == CNT_W'(DWELL - 1));
    assign last_line  = (idx_q == ADDR_W'(NUM_LINES - 1));

    // Next-state and next-output logic; enable low overrides every state.
    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        line_valid_d = line_valid_q;
        addr_err_d   = 1'b0;
        scan_busy_d  = 1'b0;
        scan_done_d  = 1'b0;
        idx_d        = idx_q;
        cnt_d        = cnt_q;

        if (!enable) begin
            state_d      = S_IDLE;
            line_d       = '0;
            line_valid_d = 1'b0;
            idx_d        = '0;
            cnt_d        = '0;
        end else begin
            case (state_q)
                S_IDLE, S_HOLD: begin
                    if (!mode && addr_valid) begin
                        if (addr_legal) begin
                            state_d      = S_HOLD;
                            line_d       = dec_line;
                            line_valid_d = 1'b1;
                        end else begin
                            state_d      = S_IDLE;
                            line_d       = '0;
                            line_valid_d = 1'b0;
                            addr_err_d   = 1'b1;
                        end
                    end else if (mode && scan_start) begin
                        state_d      = S_SCAN;
                        line_d       = NUM_LINES'(1);
                        line_valid_d = 1'b0;
                        scan_busy_d  = 1'b1;
                        idx_d        = '0;
                        cnt_d        = '0;
                    end else if (state_q == S_IDLE) begin
                        line_d       = '0;
                        line_valid_d = 1'b0;
                    end
                end
                S_SCAN: begin
                    scan_busy_d = 1'b1;
                    if (dwell_end) begin
                        cnt_d = '0;
                        if (last_line) begin
                            state_d     = S_IDLE;
                            line_d      = '0;
                            scan_busy_d = 1'b0;
                            scan_done_d = 1'b1;
                            idx_d       = '0;
                        end else begin
                            idx_d  = idx_q + ADDR_W'(1);
                            line_d = line_q << 1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d      = S_IDLE;
                    line_d       = '0;
                    line_valid_d = 1'b0;
                    idx_d        = '0;
                    cnt_d        = '0;
                end
            endcase
        end
    end

    // State, counters and all outputs are registered so lines never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            line_q       <= '0;
            line_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
            scan_busy_q  <= 1'b0;
            scan_done_q  <= 1'b0;
            idx_q        <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            line_valid_q <= line_valid_d;
            addr_err_q   <= addr_err_d;
            scan_busy_q  <= scan_busy_d;
            scan_done_q  <= scan_done_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
        end
    end

    assign line       = line_q;
    assign line_valid = line_valid_q;
    assign addr_err   = addr_err_q;
    assign scan_busy  = scan_busy_q;
    assign scan_done  = scan_done_q;

endmodule

// File: tb/tb_onehot_line_sequencer.sv
// Scoreboard bench for onehot_line_sequencer (ADDR_W=3, NUM_LINES=6, DWELL=2).
// The driver pushes the expected registered outputs for each edge; the
// monitor pops and compares one entry per edge, 1 ns after the edge.
module tb_onehot_line_sequencer;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       mode;
    logic       addr_valid;
    logic [2:0] addr;
    logic       scan_start;
    logic [5:0] line;
    logic       line_valid;
    logic       addr_err;
    logic       scan_busy;
    logic       scan_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // {line, line_valid, addr_err, scan_busy, scan_done}
    logic [9:0] exp_q[$];

    onehot_line_sequencer #(
        .ADDR_W   (3),
        .NUM_LINES(6),
        .DWELL    (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .mode      (mode),
        .addr_valid(addr_valid),
        .addr      (addr),
        .scan_start(scan_start),
        .line      (line),
        .line_valid(line_valid),
        .addr_err  (addr_err),
        .scan_busy (scan_busy),
        .scan_done (scan_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic outputs_ok(input logic [9:0] e);
        logic [9:0] act;
        act = {line, line_valid, addr_err, scan_busy, scan_done};
        return (act === e) && !$isunknown(act) && $onehot0(line) &&
               $onehot0({line_valid, scan_busy, scan_done});
    endfunction

    // Monitor: compare DUT outputs against the scoreboard after every edge.
    initial begin
        logic [9:0] e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (!outputs_ok(e)) begin
                    errors++;
                    $display("FAIL edge%0d: line=%b lv=%b err=%b busy=%b done=%b, want line=%b lv=%b err=%b busy=%b done=%b",
                             cyc, line, line_valid, addr_err, scan_busy, scan_done,
                             e[9:4], e[3], e[2], e[1], e[0]);
                end
            end
        end
    end

    task automatic step(input logic en, input logic md, input logic av,
                        input logic [2:0] a, input logic ss,
                        input logic [5:0] el, input logic elv, input logic eerr,
                        input logic ebusy, input logic edone);
        @(negedge clk);
        enable     = en;
        mode       = md;
        addr_valid = av;
        addr       = a;
        scan_start = ss;
        exp_q.push_back({el, elv, eerr, ebusy, edone});
    endtask

    // Idle scan-mode steps j=from..to after a scan_start sampled at j=0.
    task automatic scan_body(input int from, input int to);
        logic [5:0] el;
        for (int j = from; j <= to; j++) begin
            el = 6'b000001 << (j / 2);
            if (j == 12) step(1, 1, 0, 3'd0, 0, 6'b000000, 0, 0, 0, 1);
            else         step(1, 1, 0, 3'd0, 0, el,        0, 0, 1, 0);
        end
    endtask

    task automatic check_zero_now(input string name);
        checks++;
        if ({line, line_valid, addr_err, scan_busy, scan_done} !== 10'b0) begin
            errors++;
            $display("FAIL %s: line=%b lv=%b err=%b busy=%b done=%b, want all 0",
                     name, line, line_valid, addr_err, scan_busy, scan_done);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        mode       = 1'b0;
        addr_valid = 1'b0;
        addr       = 3'd0;
        scan_start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_zero_now("in_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // idle after reset
        repeat (5) step(1, 0, 0, 3'd0, 0, 6'b000000, 0, 0, 0, 0);

        // back-to-back direct decode, then hold
        step(1, 0, 1, 3'd0, 0, 6'b000001, 1, 0, 0, 0);
        step(1, 0, 1, 3'd3, 0, 6'b001000, 1, 0, 0, 0);
        step(1, 0, 1, 3'd5, 0, 6'b100000, 1, 0, 0, 0);
        step(1, 0, 0, 3'd1, 0, 6'b100000, 1, 0, 0, 0);

        // illegal addresses, then recovery
        step(1, 0, 1, 3'd6, 0, 6'b000000, 0, 1, 0, 0);
        step(1, 0, 1, 3'd7, 0, 6'b000000, 0, 1, 0, 0);
        step(1, 0, 1, 3'd2, 0, 6'b000100, 1, 0, 0, 0);
        step(1, 0, 0, 3'd2, 0, 6'b000100, 1, 0, 0, 0);

        // full scan; second scan_start and addr_valid at k+3 ignored
        step(1, 1, 0, 3'd0, 1, 6'b000001, 0, 0, 1, 0);
        scan_body(1, 2);
        step(1, 1, 1, 3'd7, 1, 6'b000010, 0, 0, 1, 0);
        scan_body(4, 12);
        step(1, 1, 0, 3'd0, 0, 6'b000000, 0, 0, 0, 0);

        // scan aborted by enable=0 at k+5; no scan_done afterwards
        step(1, 1, 0, 3'd0, 1, 6'b000001, 0, 0, 1, 0);
        scan_body(1, 4);
        step(0, 1, 0, 3'd0, 0, 6'b000000, 0, 0, 0, 0);
        repeat (10) step(1, 1, 0, 3'd0, 0, 6'b000000, 0, 0, 0, 0);

        // scan aborted by asynchronous reset between edges
        step(1, 1, 0, 3'd0, 1, 6'b000001, 0, 0, 1, 0);
        scan_body(1, 3);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero_now("async_reset");
        step(1, 1, 0, 3'd0, 0, 6'b000000, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) step(1, 1, 0, 3'd0, 0, 6'b000000, 0, 0, 0, 0);

        // direct hold of 4, then scan (with addr_valid too: scan wins)
        step(1, 0, 1, 3'd4, 0, 6'b010000, 1, 0, 0, 0);
        step(1, 1, 1, 3'd1, 1, 6'b000001, 0, 0, 1, 0);
        scan_body(1, 12);
        // scan_start in the done cycle region is accepted at the next edge
        step(1, 1, 0, 3'd0, 1, 6'b000001, 0, 0, 1, 0);
        scan_body(1, 12);

        // mode=0 with addr_valid and scan_start: decode wins
        step(1, 0, 1, 3'd1, 1, 6'b000010, 1, 0, 0, 0);
        // mode=1 without scan_start: addr_valid ignored, hold kept
        step(1, 1, 1, 3'd7, 0, 6'b000010, 1, 0, 0, 0);
        // mode=0 with scan_start only: ignored
        step(1, 0, 0, 3'd0, 1, 6'b000010, 1, 0, 0, 0);
        // enable low clears a held line
        step(0, 0, 1, 3'd3, 0, 6'b000000, 0, 0, 0, 0);
        step(1, 0, 0, 3'd3, 0, 6'b000000, 0, 0, 0, 0);

        begin
            int budget = 20;
            while (exp_q.size() > 0 && budget > 0) begin
                @(negedge clk);
                budget--;
            end
            if (exp_q.size() > 0) begin
                checks++;
                errors++;
                $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
            end
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
